// File: rtl/sobel_window_fetch.sv
// Sobel read stage: fetches packed grayscale words and streams one
// 3x3 window per pixel in raster order over a valid/ready handshake.
// Ports: clk, reset (async, active-high), start;
//        addr/en/dataR memory read port (data one cycle after en);
//        win_valid/win_ready/win_data/win_border/win_last window stream;
//        busy/done frame status.
module sobel_window_fetch #(
  parameter int IMG_W     = 352,
  parameter int IMG_H     = 288,
  parameter int BASE_ADDR = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [15:0] addr,
  output logic        en,
  input  logic [31:0] dataR,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [71:0] win_data,
  output logic        win_border,
  output logic        win_last,
  output logic        busy,
  output logic        done
);

  localparam int WPR = IMG_W / 4;
  localparam logic [15:0] L_WPR  = 16'(WPR);
  localparam logic [15:0] L_WPR1 = 16'(WPR - 1);
  localparam logic [15:0] L_W1   = 16'(IMG_W - 1);
  localparam logic [15:0] L_H1   = 16'(IMG_H - 1);
  localparam logic [15:0] L_BASE = 16'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE, S_ROW, S_EDGE, S_PRIME,
    S_EMIT, S_FETCH, S_NEXTROW, S_DONE
  } state_t;

  function automatic logic [15:0] f_addr(
    input logic [15:0] row,
    input logic [15:0] word
  );
    return L_BASE + row * L_WPR + word;
  endfunction

  // 12-pixel row = {next, cur, prev}; pixel s of cur sits at index 4+s,
  // so its left/centre/right neighbours start at index 3+s.
  function automatic logic [23:0] f_slice(
    input logic [95:0] v,
    input logic [1:0]  s
  );
    return v[8*(3+int'(s)) +: 24];
  endfunction

  state_t      r_state;
  state_t      w_state_nx;
  logic [15:0] r_row;
  logic [15:0] r_col;
  logic [15:0] r_k;
  logic [1:0]  r_sub;
  logic [2:0]  r_cnt;
  logic [31:0] r_prev [3];
  logic [31:0] r_cur  [3];
  logic [31:0] r_nxt  [3];
  logic        r_en;
  logic [15:0] r_addr;
  logic        r_wv;
  logic [71:0] r_wd;
  logic        r_wb;
  logic        r_wl;
  logic        r_busy;
  logic        r_done;

  logic        w_xfer;
  logic [1:0]  w_ld_sub;
  logic [15:0] w_ld_col;
  logic [15:0] w_emit_col;
  logic        w_emit_border;
  logic [71:0] w_emit_data;
  logic [15:0] w_pr_off;
  logic [15:0] w_pr_word;

  assign w_xfer = r_wv & win_ready;

  // Position to load next: current one if nothing is shown yet,
  // otherwise the one after the window being accepted.
  assign w_ld_sub = r_wv ? r_sub + 2'd1 : r_sub;
  assign w_ld_col = r_wv ? r_col + 16'd1 : r_col;

  assign w_emit_col    = {r_k[13:0], 2'b00} + {14'd0, w_ld_sub};
  assign w_emit_border = (w_emit_col == 16'd0) ||
                         (w_emit_col == L_W1);

  always_comb begin
    w_emit_data = '0;
    for (int i = 0; i < 3; i++)
      w_emit_data[24*i +: 24] =
        f_slice({r_nxt[i], r_cur[i], r_prev[i]}, w_ld_sub);
  end

  // Prime read order: rows r-1,r,r+1 of word 0 then of word 1.
  // Selects the read that follows read number r_cnt.
  always_comb begin
    w_pr_off  = 16'd0;
    w_pr_word = 16'd0;
    unique case (r_cnt)
      3'd0: w_pr_off = 16'd1;
      3'd1: w_pr_off = 16'd2;
      3'd2: w_pr_word = 16'd1;
      3'd3: begin
        w_pr_off  = 16'd1;
        w_pr_word = 16'd1;
      end
      default: begin
        w_pr_off  = 16'd2;
        w_pr_word = 16'd1;
      end
    endcase
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE, S_DONE:
        if (start) w_state_nx = S_ROW;
      S_ROW:
        w_state_nx = (r_row == 16'd0 || r_row == L_H1) ?
                     S_EDGE : S_PRIME;
      S_EDGE:
        if (w_xfer && r_col == L_W1) w_state_nx = S_NEXTROW;
      S_PRIME:
        if (r_cnt == 3'd6) w_state_nx = S_EMIT;
      S_EMIT:
        if (w_xfer && r_sub == 2'd3) begin
          if (r_k == L_WPR1)
            w_state_nx = S_NEXTROW;
          else if (r_k + 16'd2 < L_WPR)
            w_state_nx = S_FETCH;
        end
      S_FETCH:
        if (r_cnt == 3'd3) w_state_nx = S_EMIT;
      S_NEXTROW:
        w_state_nx = (r_row == L_H1) ? S_DONE : S_ROW;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_k     <= '0;
      r_sub   <= '0;
      r_cnt   <= '0;
      r_en    <= 1'b0;
      r_addr  <= '0;
      r_wv    <= 1'b0;
      r_wd    <= '0;
      r_wb    <= 1'b0;
      r_wl    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        r_prev[i] <= '0;
        r_cur[i]  <= '0;
        r_nxt[i]  <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_busy  <= (w_state_nx != S_IDLE) &&
                 (w_state_nx != S_DONE);
      r_done  <= (w_state_nx == S_DONE);
      r_en    <= 1'b0;
      unique case (r_state)
        S_IDLE, S_DONE:
          if (start) r_row <= '0;
        S_ROW: begin
          r_col <= '0;
          r_k   <= '0;
          r_sub <= '0;
          r_cnt <= '0;
          if (w_state_nx == S_PRIME) begin
            for (int i = 0; i < 3; i++) r_prev[i] <= '0;
            r_en   <= 1'b1;
            r_addr <= f_addr(r_row - 16'd1, 16'd0);
          end
        end
        S_EDGE: begin
          if (!r_wv || (w_xfer && r_col != L_W1)) begin
            r_wv  <= 1'b1;
            r_wd  <= '0;
            r_wb  <= 1'b1;
            r_wl  <= (r_row == L_H1) && (w_ld_col == L_W1);
            r_col <= w_ld_col;
          end else if (w_xfer) begin
            r_wv  <= 1'b0;
            r_wb  <= 1'b0;
            r_wl  <= 1'b0;
            r_col <= '0;
          end
        end
        S_PRIME: begin
          r_cnt <= (r_cnt == 3'd6) ? 3'd0 : r_cnt + 3'd1;
          if (r_cnt < 3'd5) begin
            r_en   <= 1'b1;
            r_addr <= f_addr(r_row - 16'd1 + w_pr_off, w_pr_word);
          end
          unique case (r_cnt)
            3'd1: r_cur[0] <= dataR;
            3'd2: r_cur[1] <= dataR;
            3'd3: r_cur[2] <= dataR;
            3'd4: r_nxt[0] <= dataR;
            3'd5: r_nxt[1] <= dataR;
            3'd6: r_nxt[2] <= dataR;
            default: ;
          endcase
        end
        S_EMIT: begin
          if (!r_wv || (w_xfer && r_sub != 2'd3)) begin
            r_wv  <= 1'b1;
            r_wd  <= w_emit_border ? '0 : w_emit_data;
            r_wb  <= w_emit_border;
            r_wl  <= 1'b0;
            r_sub <= w_ld_sub;
          end else if (w_xfer) begin
            r_wv  <= 1'b0;
            r_wb  <= 1'b0;
            r_sub <= '0;
            r_cnt <= '0;
            if (r_k != L_WPR1) begin
              r_k <= r_k + 16'd1;
              for (int i = 0; i < 3; i++) begin
                r_prev[i] <= r_cur[i];
                r_cur[i]  <= r_nxt[i];
              end
              // Last word of the row has no right neighbour word.
              if (w_state_nx == S_FETCH) begin
                r_en   <= 1'b1;
                r_addr <= f_addr(r_row - 16'd1, r_k + 16'd2);
              end else begin
                for (int i = 0; i < 3; i++) r_nxt[i] <= '0;
              end
            end
          end
        end
        S_FETCH: begin
          r_cnt <= (r_cnt == 3'd3) ? 3'd0 : r_cnt + 3'd1;
          if (r_cnt < 3'd2) begin
            r_en   <= 1'b1;
            r_addr <= f_addr(r_row + {13'd0, r_cnt}, r_k + 16'd1);
          end
          unique case (r_cnt)
            3'd1: r_nxt[0] <= dataR;
            3'd2: r_nxt[1] <= dataR;
            3'd3: r_nxt[2] <= dataR;
            default: ;
          endcase
        end
        S_NEXTROW:
          if (w_state_nx == S_ROW) r_row <= r_row + 16'd1;
      endcase
    end
  end

  assign addr       = r_addr;
  assign en         = r_en;
  assign win_valid  = r_wv;
  assign win_data   = r_wd;
  assign win_border = r_wb;
  assign win_last   = r_wl;
  assign busy       = r_busy;
  assign done       = r_done;

endmodule
